// File: rtl/rkold_prev_writer_if.sv
// -----------------------------------------------------------------------------
// rkold_prev_writer_if
// Bundles the control, input-stream and memory-write signals of the
// rKold_prev packing writer.
//   start / base_address / element_count : transfer request
//   in_data / in_valid / in_ready        : residual element stream
//   mem_data / mem_address / mem_write_enable : packed memory write port
//   busy / done                          : transfer status
// master : the side that requests transfers and supplies elements.
// slave  : the writer itself.
// -----------------------------------------------------------------------------
interface rkold_prev_writer_if #(
   parameter int element_width = 32,
   parameter int no_of_units   = 8,
   parameter int address_width = 20
);
   logic                                   start;
   logic [address_width-1:0]               base_address;
   logic [address_width-1:0]               element_count;
   logic [element_width-1:0]               in_data;
   logic                                   in_valid;
   logic                                   in_ready;
   logic [element_width*no_of_units-1:0]   mem_data;
   logic [address_width-1:0]               mem_address;
   logic                                   mem_write_enable;
   logic                                   busy;
   logic                                   done;

   modport master (
      output start, base_address, element_count, in_data, in_valid,
      input  in_ready, mem_data, mem_address, mem_write_enable, busy, done
   );

   modport slave (
      input  start, base_address, element_count, in_data, in_valid,
      output in_ready, mem_data, mem_address, mem_write_enable, busy, done
   );
endinterface

// File: rtl/rkold_prev_writer.sv
// -----------------------------------------------------------------------------
// rkold_prev_writer
// Accepts residual elements one per cycle and packs no_of_units of them into
// one wide word, writing each word to consecutive addresses from a
// programmable base. A partial final word is zero-padded; done pulses once at
// the end of the transfer.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : rkold_prev_writer_if.slave (request, element stream, memory write,
//           status)
// All outputs come from registers or from the state register alone, so there
// is no combinational path from in_valid to in_ready.
// -----------------------------------------------------------------------------
module rkold_prev_writer #(
   parameter int element_width = 32,
   parameter int no_of_units   = 8,
   parameter int address_width = 20
) (
   input  logic                 clk,
   input  logic                 rst_n,
   rkold_prev_writer_if.slave   bus
);

   localparam int lane_width = $clog2(no_of_units);
   localparam logic [lane_width-1:0] last_lane = lane_width'(no_of_units - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                                        state_q, state_d;
   logic [address_width-1:0]                      ptr_q, ptr_d;
   logic [address_width-1:0]                      remaining_q, remaining_d;
   logic [lane_width-1:0]                         lane_q, lane_d;
   logic [no_of_units-1:0][element_width-1:0]     pack_q, pack_d;

   // Next-state and datapath update.
   // NOTE: every signal written here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      remaining_d = remaining_q;
      lane_d      = lane_q;
      pack_d      = pack_q;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               ptr_d       = bus.base_address;
               remaining_d = bus.element_count;
               lane_d      = '0;
               pack_d      = '0;
               state_d     = (bus.element_count != '0) ? FILL : DONE;
            end
         end

         FILL: begin
            // in_ready is high for the whole of FILL, so in_valid alone
            // marks a handshake.
            if (bus.in_valid) begin
               pack_d[lane_q] = bus.in_data;
               lane_d         = lane_q + 1'b1;
               remaining_d    = remaining_q - 1'b1;
               // Word complete when the top lane is filled or the last
               // element of the transfer has arrived.
               if (lane_q == last_lane || remaining_q == address_width'(1)) begin
                  state_d = WRITE;
               end
            end
         end

         WRITE: begin
            // The word is on the bus this cycle; prepare for the next one.
            // The pointer wraps modulo 2^address_width by plain overflow.
            ptr_d   = ptr_q + 1'b1;
            lane_d  = '0;
            pack_d  = '0;
            state_d = (remaining_q != '0) ? FILL : DONE;
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the pre-edge value of every other flop.
   // NOTE: the pack buffer is reset along with the control state; it drives
   // mem_data directly, which must read zero out of reset and a partial word
   // in flight must be discarded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         remaining_q <= '0;
         lane_q      <= '0;
         pack_q      <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         remaining_q <= remaining_d;
         lane_q      <= lane_d;
         pack_q      <= pack_d;
      end
   end

   // Outputs: registered data/address, strobes decoded from state.
   assign bus.in_ready         = (state_q == FILL);
   assign bus.mem_write_enable = (state_q == WRITE);
   assign bus.busy             = (state_q != IDLE);
   assign bus.done             = (state_q == DONE);
   assign bus.mem_data         = pack_q;
   assign bus.mem_address      = ptr_q;

endmodule
